// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL timer block and the status read mux.
// Prescale defaults, status bit positions and a prescaler width helper.
package jtopl_pkg;

    localparam int JTOPL_PRE_A = 4;
    localparam int JTOPL_PRE_B = 16;

    localparam int JTOPL_ST_IRQ    = 7;
    localparam int JTOPL_ST_FLAG_A = 6;
    localparam int JTOPL_ST_FLAG_B = 5;

    function automatic int pre_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jtopl_timer.sv
// One OPL timer: load edge, prescaler, 8-bit up counter, flag, overflow pulse.
// Counts only while the registered load is high; a fresh load edge reloads.
module jtopl_timer
    import jtopl_pkg::*;
#(
    parameter int PRE = JTOPL_PRE_A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cenop,
    input  logic       zero,
    input  logic       fast,
    input  logic [7:0] value,
    input  logic       load,
    input  logic       flagen,
    input  logic       clr_flag,
    output logic       flag,
    output logic       overflow
);

    localparam int PW = pre_width(PRE);

    logic [PW-1:0] pre;
    logic [7:0]    cnt;
    logic          load_q;
    logic          tick;
    logic          ov;

    assign tick = fast || (pre == PW'(PRE - 1));
    assign ov   = cenop && zero && load_q && tick && (cnt == 8'hFF);

    // Load edge capture, prescaler and counter, all gated by cenop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q <= 1'b0;
            cnt    <= 8'd0;
            pre    <= '0;
        end else if (cenop) begin
            load_q <= load;
            if (load && !load_q) begin
                cnt <= value;
                pre <= '0;
            end else if (load_q && zero) begin
                pre <= tick ? '0 : pre + PW'(1);
                if (tick)
                    cnt <= (cnt == 8'hFF) ? value : cnt + 8'd1;
            end
        end
    end

    // Flag set on overflow beats a concurrent clear; pulse follows overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= ov;
            if (ov && flagen)
                flag <= 1'b1;
            else if (clr_flag)
                flag <= 1'b0;
        end
    end

endmodule

// File: rtl/jtopl_timers.sv
// OPL timers A and B with status flags and active-low IRQ.
// Optional JTOPL_TIMER_FAST_EN adds a `fast` input that bypasses prescalers.
module jtopl_timers
    import jtopl_pkg::*;
#(
    parameter int PRE_A = JTOPL_PRE_A,
    parameter int PRE_B = JTOPL_PRE_B
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cenop,
    input  logic       zero,
`ifdef JTOPL_TIMER_FAST_EN
    input  logic       fast,
`endif
    input  logic [7:0] value_A,
    input  logic [7:0] value_B,
    input  logic       load_A,
    input  logic       load_B,
    input  logic       flagen_A,
    input  logic       flagen_B,
    input  logic       clr_flag_A,
    input  logic       clr_flag_B,
    output logic       flag_A,
    output logic       flag_B,
    output logic       overflow_A,
    output logic       irq_n
);

    logic fast_en;
    logic unused_ovf_b;

`ifdef JTOPL_TIMER_FAST_EN
    assign fast_en = fast;
`else
    assign fast_en = 1'b0;
`endif

    jtopl_timer #(.PRE(PRE_A)) u_timer_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .cenop    (cenop),
        .zero     (zero),
        .fast     (fast_en),
        .value    (value_A),
        .load     (load_A),
        .flagen   (flagen_A),
        .clr_flag (clr_flag_A),
        .flag     (flag_A),
        .overflow (overflow_A)
    );

    jtopl_timer #(.PRE(PRE_B)) u_timer_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .cenop    (cenop),
        .zero     (zero),
        .fast     (fast_en),
        .value    (value_B),
        .load     (load_B),
        .flagen   (flagen_B),
        .clr_flag (clr_flag_B),
        .flag     (flag_B),
        .overflow (unused_ovf_b)
    );

    assign irq_n = ~(flag_A | flag_B);

endmodule

// File: tb/tb_jtopl_timers.sv
// Self-checking bench for jtopl_timers: directed steps plus random traffic
// checked each clock against a strobes-remaining reference model.
module tb_jtopl_timers;

    localparam int PA = 4;
    localparam int PB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cenop = 1'b1;
    logic       zero = 1'b0;
    logic       fast = 1'b0;
    logic [7:0] value_A = 8'd0;
    logic [7:0] value_B = 8'd0;
    logic       load_A = 1'b0;
    logic       load_B = 1'b0;
    logic       flagen_A = 1'b0;
    logic       flagen_B = 1'b0;
    logic       clr_flag_A = 1'b0;
    logic       clr_flag_B = 1'b0;
    logic       flag_A;
    logic       flag_B;
    logic       overflow_A;
    logic       irq_n;

    int checks = 0;
    int errors = 0;
    int ovf_seen = 0;

    // Model: strobes left until overflow, running state, flags, pulse
    int rem [2];
    bit run [2];
    bit mflag [2];
    bit movf;

    jtopl_timers dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cenop      (cenop),
        .zero       (zero),
`ifdef JTOPL_TIMER_FAST_EN
        .fast       (fast),
`endif
        .value_A    (value_A),
        .value_B    (value_B),
        .load_A     (load_A),
        .load_B     (load_B),
        .flagen_A   (flagen_A),
        .flagen_B   (flagen_B),
        .clr_flag_A (clr_flag_A),
        .clr_flag_B (clr_flag_B),
        .flag_A     (flag_A),
        .flag_B     (flag_B),
        .overflow_A (overflow_A),
        .irq_n      (irq_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic bit adv(input int i, input bit ld,
                               input logic [7:0] v, input int p);
        bit ev = 1'b0;
        int per = (fast ? 1 : p) * (256 - int'(v));
        if (cenop) begin
            if (ld && !run[i]) begin
                rem[i] = per;
            end else if (run[i] && zero) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    ev = 1'b1;
                    rem[i] = per;
                end
            end
            run[i] = ld;
        end
        return ev;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0;
            run[i] = 1'b0;
            mflag[i] = 1'b0;
        end
        movf = 1'b0;
    endtask

    task automatic check_all();
        chk("flag_A", flag_A, mflag[0]);
        chk("flag_B", flag_B, mflag[1]);
        chk("overflow_A", overflow_A, movf);
        chk("irq_n", irq_n, ~(mflag[0] | mflag[1]));
    endtask

    task automatic cyc();
        bit ea, eb, fa, fb, ca, cb;
        ea = adv(0, load_A, value_A, PA);
        eb = adv(1, load_B, value_B, PB);
        fa = flagen_A; fb = flagen_B;
        ca = clr_flag_A; cb = clr_flag_B;
        @(posedge clk);
        #1;
        if (ea && fa) mflag[0] = 1'b1;
        else if (ca) mflag[0] = 1'b0;
        if (eb && fb) mflag[1] = 1'b1;
        else if (cb) mflag[1] = 1'b0;
        movf = ea;
        if (overflow_A) ovf_seen++;
        check_all();
    endtask

    task automatic strobes(input int n);
        for (int k = 0; k < n; k++) begin
            zero = 1'b1;
            cyc();
            zero = 1'b0;
            repeat (3) cyc();
        end
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_flag_A", flag_A, 1'b0);
        chk("rst_flag_B", flag_B, 1'b0);
        chk("rst_ovf", overflow_A, 1'b0);
        chk("rst_irq", irq_n, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) cyc();

        // Timer A, value FE: overflow every 8 strobes
        value_A = 8'hFE; flagen_A = 1'b1; load_A = 1'b1;
        cyc();
        ovf_seen = 0;
        strobes(7);
        chk("a_no_ovf_7", overflow_A | flag_A, 1'b0);
        strobes(1);
        chk("a_flag_8", flag_A, 1'b1);
        chk("a_irq_8", irq_n, 1'b0);
        strobes(16);
        chk("a_three_ovf", 1'(ovf_seen == 3), 1'b1);

        // Timer B, value FF: flag after 16 strobes, then clear
        load_A = 1'b0; clr_flag_A = 1'b1;
        cyc();
        clr_flag_A = 1'b0;
        value_B = 8'hFF; flagen_B = 1'b1; load_B = 1'b1;
        cyc();
        strobes(15);
        chk("b_flag_15", flag_B, 1'b0);
        strobes(1);
        chk("b_flag_16", flag_B, 1'b1);
        chk("b_irq", irq_n, 1'b0);
        clr_flag_B = 1'b1;
        cyc();
        clr_flag_B = 1'b0;
        chk("b_clr", flag_B, 1'b0);
        chk("b_irq_clr", irq_n, 1'b1);
        load_B = 1'b0;
        cyc();

        // flagen_A off: pulses every 4 strobes, no flag
        flagen_A = 1'b0; value_A = 8'hFF; load_A = 1'b1;
        cyc();
        ovf_seen = 0;
        strobes(12);
        chk("noflag_pulses", 1'(ovf_seen == 3), 1'b1);
        chk("noflag_flag", flag_A, 1'b0);
        chk("noflag_irq", irq_n, 1'b1);

        // Set beats clear on the overflow cycle
        flagen_A = 1'b1; clr_flag_A = 1'b1;
        strobes(3);
        zero = 1'b1;
        cyc();
        zero = 1'b0;
        chk("set_wins", flag_A, 1'b1);
        clr_flag_A = 1'b0;
        cyc();
        clr_flag_A = 1'b1;
        cyc();
        clr_flag_A = 1'b0;
        chk("clr_after", flag_A, 1'b0);

        // Load drop at cnt 80, hold, re-rise with F0
        load_A = 1'b0;
        cyc();
        value_A = 8'h70; load_A = 1'b1;
        cyc();
        strobes(64);
        load_A = 1'b0;
        cyc();
        ovf_seen = 0;
        strobes(20);
        chk("hold_no_ovf", 1'(ovf_seen == 0), 1'b1);
        value_A = 8'hF0; load_A = 1'b1;
        cyc();
        strobes(63);
        chk("rerise_63", 1'(ovf_seen == 0), 1'b1);
        strobes(1);
        chk("rerise_64", 1'(ovf_seen == 1), 1'b1);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cenop = ($urandom_range(0, 7) != 0);
            zero = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 63) == 0) load_A = ~load_A;
            if ($urandom_range(0, 63) == 0) load_B = ~load_B;
            if ($urandom_range(0, 31) == 0) value_A = 8'hE0 | 8'($urandom);
            if ($urandom_range(0, 31) == 0) value_B = 8'hF0 | 8'($urandom);
            if ($urandom_range(0, 15) == 0) flagen_A = ~flagen_A;
            if ($urandom_range(0, 15) == 0) flagen_B = ~flagen_B;
            clr_flag_A = ($urandom_range(0, 15) == 0);
            clr_flag_B = ($urandom_range(0, 15) == 0);
            cyc();
        end
        cenop = 1'b1; zero = 1'b0;
        clr_flag_A = 1'b0; clr_flag_B = 1'b0;

        // Async reset mid-count with flag_A set
        load_A = 1'b0; load_B = 1'b0;
        cyc();
        value_A = 8'hFF; flagen_A = 1'b1; load_A = 1'b1;
        cyc();
        strobes(6);
        chk("pre_rst_flag", flag_A, 1'b1);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("mid_rst_flag_A", flag_A, 1'b0);
        chk("mid_rst_flag_B", flag_B, 1'b0);
        chk("mid_rst_ovf", overflow_A, 1'b0);
        chk("mid_rst_irq", irq_n, 1'b1);
        #1 rst_n = 1'b1;
        load_A = 1'b0;
        cyc();
        strobes(8);
        chk("idle_after_rst", flag_A, 1'b0);

`ifdef JTOPL_TIMER_FAST_EN
        // Prescaler bypass: FE overflows after 2 strobes
        fast = 1'b1; value_A = 8'hFE; load_A = 1'b1;
        cyc();
        ovf_seen = 0;
        strobes(1);
        chk("fast_1", 1'(ovf_seen == 0), 1'b1);
        strobes(1);
        chk("fast_2", 1'(ovf_seen == 1), 1'b1);
        load_A = 1'b0;
        cyc();
        fast = 1'b0;
        cyc();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
